// File: rtl/kgp_ctrl_pkg.sv
// Shared encodings for the KGP-RISC multi-cycle sequencer: FSM states,
// decoder op classes and writeback source selects.
package kgp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam logic [2:0] OP_ALU    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_STORE  = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_CALL   = 3'd4;
    localparam logic [2:0] OP_HALT   = 3'd5;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_RA  = 2'd2;

    // Classes 6 and 7 are unassigned and send the core to ERR.
    function automatic logic op_is_legal(input logic [2:0] cls);
        return cls <= OP_HALT;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/kgp_wait_timer.sv
// Request wait timer: counts cycles a memory request spends waiting for
// ready and flags expiry on the cycle the TIMEOUT-th wait would be reached.
module kgp_wait_timer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Expiry coincides with the edge that would make the count equal TIMEOUT.
    assign expire = enable && (count_q == LAST);

endmodule

// File: rtl/kgp_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the KGP-RISC core.
// Owns pc, the instruction register and the retired-instruction counter.
module kgp_multicycle_ctrl
    import kgp_ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IADDR_W  = 10,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic [XLEN-1:0]    instr,
    input  logic [2:0]         op_class,
    input  logic               br_taken,
    input  logic [IADDR_W-1:0] br_target,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ready,
    output logic               alu_en,
    output logic               rf_we,
    output logic [1:0]         wb_sel,
    output logic [IADDR_W-1:0] pc,
    output logic [IADDR_W-1:0] npc,
    output logic [2:0]         state,
    output logic               halted,
    output logic               bus_err,
    output logic [31:0]        instr_count
);

    // Handshake: req is a level derived from state and is held until the
    // transfer completes on the first rising edge where req && ready.
    // ready while the matching req is low carries no meaning and is ignored.

    state_t             state_q, state_d;
    logic [IADDR_W-1:0] pc_q, pc_d;
    logic [XLEN-1:0]    instr_q;
    logic [2:0]         cls_q;
    logic [31:0]        count_q;
    logic               load_instr;
    logic               retire;
    logic               timer_clear;
    logic               timer_en;
    logic               timer_expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= IADDR_W'(RESET_PC);
            instr_q <= '0;
            cls_q   <= OP_ALU;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (load_instr) begin
                instr_q <= imem_rdata;
            end
            if (state_q == ST_DECODE) begin
                cls_q <= op_class;
            end
            if (retire) begin
                count_q <= sat_inc32(count_q);
            end
        end
    end

    assign npc = pc_q + IADDR_W'(1);

    // Any state change clears the timer, which covers every entry to FETCH/MEM.
    assign timer_en    = ((state_q == ST_FETCH) && !imem_ready) ||
                         ((state_q == ST_MEM)   && !dmem_ready);
    assign timer_clear = (state_d != state_q);

    kgp_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .expire (timer_expire)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        alu_en     = 1'b0;
        rf_we      = 1'b0;
        wb_sel     = WB_ALU;
        load_instr = 1'b0;
        retire     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    load_instr = 1'b1;
                    state_d    = ST_DECODE;
                end else if (timer_expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_DECODE: begin
                if (op_class == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (!op_is_legal(op_class)) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_en = 1'b1;
                case (cls_q)
                    OP_LOAD, OP_STORE: state_d = ST_MEM;
                    OP_BRANCH: begin
                        pc_d    = br_taken ? br_target : npc;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == OP_STORE);
                if (dmem_ready) begin
                    if (cls_q == OP_STORE) begin
                        pc_d    = npc;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timer_expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_WB: begin
                rf_we = 1'b1;
                case (cls_q)
                    OP_LOAD: wb_sel = WB_MEM;
                    OP_CALL: wb_sel = WB_RA;
                    default: wb_sel = WB_ALU;
                endcase
                pc_d    = (cls_q == OP_CALL) ? br_target : npc;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT, ST_ERR: begin
                state_d = state_q;
            end
            default: state_d = ST_ERR;
        endcase
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign state       = state_q;
    assign halted      = (state_q == ST_HALT);
    assign bus_err     = (state_q == ST_ERR);
    assign instr_count = count_q;

endmodule

// File: tb/tb_kgp_multicycle_ctrl.sv
// Bench for kgp_multicycle_ctrl: scripted and random instruction stream with
// a per-retire scoreboard, plus halt, illegal-class, timeout and reset cases.
module tb_kgp_multicycle_ctrl;

    localparam int XLEN    = 32;
    localparam int IADDR_W = 10;
    localparam int TIMEOUT = 4;

    localparam logic [2:0] C_ALU = 3'd0, C_LOAD = 3'd1, C_STORE = 3'd2;
    localparam logic [2:0] C_BRANCH = 3'd3, C_CALL = 3'd4, C_HALT = 3'd5;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               imem_req;
    logic [IADDR_W-1:0] imem_addr;
    logic               imem_ready = 1'b0;
    logic [XLEN-1:0]    imem_rdata = '0;
    logic [XLEN-1:0]    instr;
    logic [2:0]         op_class;
    logic               br_taken;
    logic [IADDR_W-1:0] br_target;
    logic               dmem_req;
    logic               dmem_we;
    logic               dmem_ready = 1'b0;
    logic               alu_en;
    logic               rf_we;
    logic [1:0]         wb_sel;
    logic [IADDR_W-1:0] pc;
    logic [IADDR_W-1:0] npc;
    logic [2:0]         state;
    logic               halted;
    logic               bus_err;
    logic [31:0]        instr_count;

    always #5 clk = ~clk;

    // Decoder stand-in: class, branch condition and target come from instr.
    assign op_class  = instr[2:0];
    assign br_target = instr[12:3];
    assign br_taken  = instr[31];

    kgp_multicycle_ctrl #(
        .XLEN     (XLEN),
        .IADDR_W  (IADDR_W),
        .RESET_PC (0),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .op_class    (op_class),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ready  (dmem_ready),
        .alu_en      (alu_en),
        .rf_we       (rf_we),
        .wb_sel      (wb_sel),
        .pc          (pc),
        .npc         (npc),
        .state       (state),
        .halted      (halted),
        .bus_err     (bus_err),
        .instr_count (instr_count)
    );

    typedef struct packed {
        logic [9:0]  pc;
        logic [31:0] cnt;
        logic [7:0]  cyc;
        logic [3:0]  alu_n;
        logic [3:0]  rf_n;
        logic [1:0]  wb;
        logic [9:0]  npc_wb;
        logic [7:0]  dm_n;
        logic        dm_we;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Retire monitor: every FETCH entry closes one instruction.
    logic [2:0] prev_state = 3'd7;
    bit         after_rst = 1'b1;
    int         m_cyc = 0, m_alu = 0, m_rf = 0, m_dm = 0;
    logic [1:0] m_wb = '0;
    logic [9:0] m_npc = '0;
    logic       m_we = 1'b0;
    exp_t       e;

    task automatic clear_mon();
        m_cyc = 0; m_alu = 0; m_rf = 0; m_dm = 0;
        m_wb = '0; m_npc = '0; m_we = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            after_rst = 1'b1;
            clear_mon();
        end else begin
            m_cyc++;
            if (alu_en) m_alu++;
            if (rf_we) begin
                m_rf++;
                m_wb  = wb_sel;
                m_npc = npc;
            end
            if (dmem_req) begin
                m_dm++;
                m_we = m_we | dmem_we;
            end
            if (state == 3'd0 && (prev_state != 3'd0 || after_rst)) begin
                if (after_rst) begin
                    after_rst = 1'b0;
                end else if (exp_q.size() == 0) begin
                    check_val("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("ret_pc", 32'(pc), 32'(e.pc));
                    check_val("ret_count", instr_count, e.cnt);
                    check_val("ret_cycles", 32'(m_cyc), 32'(e.cyc));
                    check_val("ret_alu_en_n", 32'(m_alu), 32'(e.alu_n));
                    check_val("ret_rf_we_n", 32'(m_rf), 32'(e.rf_n));
                    check_val("ret_wb_sel", 32'(m_wb), 32'(e.wb));
                    check_val("ret_npc_wb", 32'(m_npc), 32'(e.npc_wb));
                    check_val("ret_dmem_req_n", 32'(m_dm), 32'(e.dm_n));
                    check_val("ret_dmem_we", 32'(m_we), 32'(e.dm_we));
                    check_val("ret_imem_req", 32'(imem_req), 32'd1);
                end
                clear_mon();
            end
        end
        prev_state = state;
    end

    logic [9:0]  pc_m = '0;
    logic [31:0] cnt_m = '0;

    function automatic logic [4:0] strobes();
        return {imem_req, dmem_req, dmem_we, alu_en, rf_we};
    endfunction

    task automatic reset_dut();
        rst        = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        imem_rdata = '0;
        repeat (2) step();
        rst   = 1'b0;
        pc_m  = '0;
        cnt_m = '0;
        exp_q.delete();
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_state"}, 32'(state), 32'd0);
        check_val({tag, "_pc"}, 32'(pc), 32'd0);
        check_val({tag, "_npc"}, 32'(npc), 32'd1);
        check_val({tag, "_instr"}, instr, 32'd0);
        check_val({tag, "_count"}, instr_count, 32'd0);
        check_val({tag, "_flags"}, {30'd0, halted, bus_err}, 32'd0);
        check_val({tag, "_strobes"}, 32'(strobes()), 32'b10000);
    endtask

    // Drives one instruction from FETCH cycle 0 through to the next FETCH
    // entry; iw/dw are ready-low cycles on the fetch and data accesses.
    task automatic run_instr(input logic [2:0] cls, input logic taken,
                             input logic [9:0] tgt, input int iw, input int dw);
        logic [31:0] word;
        logic [9:0]  npc_m;
        bit          is_mem;
        bit          has_wb;
        exp_t        x;
        word   = {taken, 18'($urandom), tgt, cls};
        npc_m  = pc_m + 10'd1;
        is_mem = (cls == C_LOAD) || (cls == C_STORE);
        has_wb = (cls == C_ALU) || (cls == C_LOAD) || (cls == C_CALL);
        case (cls)
            C_LOAD:   x.cyc = 8'(5 + iw + dw);
            C_STORE:  x.cyc = 8'(4 + iw + dw);
            C_BRANCH: x.cyc = 8'(3 + iw);
            default:  x.cyc = 8'(4 + iw);
        endcase
        case (cls)
            C_BRANCH: x.pc = taken ? tgt : npc_m;
            C_CALL:   x.pc = tgt;
            default:  x.pc = npc_m;
        endcase
        cnt_m    = (cnt_m == 32'hFFFF_FFFF) ? cnt_m : cnt_m + 32'd1;
        x.cnt    = cnt_m;
        x.alu_n  = 4'd1;
        x.rf_n   = has_wb ? 4'd1 : 4'd0;
        x.wb     = (cls == C_LOAD) ? 2'd1 : (cls == C_CALL) ? 2'd2 : 2'd0;
        x.npc_wb = has_wb ? npc_m : 10'd0;
        x.dm_n   = is_mem ? 8'(dw + 1) : 8'd0;
        x.dm_we  = (cls == C_STORE);
        exp_q.push_back(x);
        pc_m = x.pc;

        for (int i = 0; i < iw; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            dmem_ready = 1'($urandom_range(0, 1));
            step();
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        dmem_ready = 1'b0;
        step();
        imem_ready = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        dmem_ready = 1'($urandom_range(0, 1));
        step();
        imem_ready = 1'($urandom_range(0, 1));
        dmem_ready = 1'($urandom_range(0, 1));
        step();
        if (is_mem) begin
            for (int i = 0; i < dw; i++) begin
                dmem_ready = 1'b0;
                imem_ready = 1'($urandom_range(0, 1));
                step();
            end
            dmem_ready = 1'b1;
            step();
            dmem_ready = 1'b0;
            if (cls == C_LOAD) step();
        end else if (cls != C_BRANCH) begin
            imem_ready = 1'($urandom_range(0, 1));
            step();
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
    endtask

    // Fetches a word and steps until the cycle after DECODE.
    task automatic fetch_decode(input logic [31:0] word);
        imem_ready = 1'b1;
        imem_rdata = word;
        step();
        imem_ready = 1'b0;
        step();
    endtask

    initial begin
        reset_dut();
        check_reset("rst0");

        run_instr(C_ALU,    1'b0, 10'h000, 0, 0);
        run_instr(C_LOAD,   1'b0, 10'h000, 0, 3);
        run_instr(C_STORE,  1'b0, 10'h000, 1, 0);
        run_instr(C_ALU,    1'b0, 10'h000, 2, 1);
        run_instr(C_CALL,   1'b0, 10'h3FF, 0, 0);
        run_instr(C_BRANCH, 1'b0, 10'h123, 0, 0);
        run_instr(C_BRANCH, 1'b1, 10'h055, 0, 0);
        run_instr(C_CALL,   1'b0, 10'h010, 0, 0);
        run_instr(C_CALL,   1'b0, 10'h200, 1, 0);
        for (int n = 0; n < 24; n++) begin
            run_instr(3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                      10'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        step();
        check_val("sb_drain_seq", 32'(exp_q.size()), 32'd0);

        // HALT is terminal with every strobe low.
        fetch_decode({29'd0, C_HALT});
        for (int i = 0; i < 20; i++) begin
            check_val("halt_hold", {24'd0, state, halted, bus_err, strobes()},
                      {24'd0, 3'd5, 1'b1, 1'b0, 5'd0});
            imem_ready = 1'($urandom_range(0, 1));
            dmem_ready = 1'($urandom_range(0, 1));
            step();
        end
        check_val("halt_count", instr_count, cnt_m);
        reset_dut();
        check_reset("rst_halt");

        for (int c = 6; c < 8; c++) begin
            reset_dut();
            fetch_decode({29'd0, 3'(c)});
            for (int i = 0; i < 3; i++) begin
                check_val("illegal_err", {24'd0, state, halted, bus_err, strobes()},
                          {24'd0, 3'd6, 1'b0, 1'b1, 5'd0});
                step();
            end
        end

        // Fetch timeout: FETCH entered at cycle 0, ERR at cycle TIMEOUT.
        reset_dut();
        repeat (TIMEOUT - 1) step();
        check_val("ito_pre_state", 32'(state), 32'd0);
        check_val("ito_pre_req", 32'(imem_req), 32'd1);
        step();
        check_val("ito_state", 32'(state), 32'd6);
        check_val("ito_bus_err", 32'(bus_err), 32'd1);
        check_val("ito_req", 32'(imem_req), 32'd0);
        reset_dut();
        check_reset("rst_ito");

        // rst wins over the timeout edge.
        repeat (TIMEOUT - 1) step();
        rst = 1'b1;
        step();
        check_val("rst_prio_state", 32'(state), 32'd0);
        check_val("rst_prio_err", 32'(bus_err), 32'd0);
        reset_dut();

        // Data-side timeout.
        fetch_decode({29'd0, C_LOAD});
        step();
        repeat (TIMEOUT - 1) step();
        check_val("dto_pre_state", 32'(state), 32'd3);
        check_val("dto_pre_req", 32'(dmem_req), 32'd1);
        step();
        check_val("dto_state", 32'(state), 32'd6);
        check_val("dto_req", 32'(dmem_req), 32'd0);
        check_val("dto_bus_err", 32'(bus_err), 32'd1);

        // rst in the middle of a MEM wait abandons the access.
        reset_dut();
        run_instr(C_ALU, 1'b0, 10'h000, 0, 0);
        check_val("pre_rst_count", instr_count, 32'd1);
        fetch_decode({29'd0, C_STORE});
        step();
        step();
        check_val("mem_wait_state", 32'(state), 32'd3);
        check_val("mem_wait_we", 32'(dmem_we), 32'd1);
        rst = 1'b1;
        step();
        check_reset("rst_mem");
        rst = 1'b0;
        step();
        check_val("sb_drain_end", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/kgp_multicycle_ctrl.md
# kgp_multicycle_ctrl

Parametrised multi-cycle sequencer for the KGP-RISC core. It replaces the single-cycle top-level control with an explicit FETCH/DECODE/EXEC/MEM/WB state machine. It owns the PC and the instruction register, and talks to instruction and data memories through req/ready handshakes, so variable-latency memories can be used. It drives the register-file, ALU and memory strobes for the existing datapath, and adds halt, a bus-timeout error and a retired-instruction counter.

## Interface
- XLEN, 32, instruction/data word width
- IADDR_W, 10, PC / instruction-memory word-address width
- RESET_PC, 0, PC value loaded on reset
- TIMEOUT, 255, max cycles a memory request may wait for ready (1..2^16-1)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  IADDR_W  fetch address (= pc)
- imem_ready  in  1  fetch data valid this cycle
- imem_rdata  in  XLEN  fetched instruction
- instr  out  XLEN  instruction register, feeds decoder
- op_class  in  3  class from decoder (combinational on instr)
- br_taken  in  1  branch condition from branch logic
- br_target  in  IADDR_W  branch/call target
- dmem_req  out  1  data memory request
- dmem_we  out  1  write qualifier, valid with dmem_req
- dmem_ready  in  1  data access complete this cycle
- alu_en  out  1  ALU flag-register update strobe
- rf_we  out  1  register-file write strobe
- wb_sel  out  2  writeback source: 0 ALU, 1 MEM, 2 return address
- pc  out  IADDR_W  current PC
- npc  out  IADDR_W  pc+1 mod 2^IADDR_W (return address)
- state  out  3  current state encoding
- halted  out  1  sticky HALT indication
- bus_err  out  1  sticky timeout / illegal-class indication
- instr_count  out  32  retired instructions, saturating

## Operation
- op_class encodings: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 CALL, 5 HALT; 6–7 are illegal.
- Reset values: state FETCH, pc RESET_PC, instr 0, instr_count 0, halted 0, bus_err 0. All strobes are combinational from state, so imem_req=1 immediately after reset and every other strobe is 0.
- FETCH:
  - imem_req=1. Hold imem_addr stable until imem_ready.
  - On imem_ready: instr <= imem_rdata, go to DECODE.
- DECODE: one cycle. HALT class goes to HALT; illegal class goes to ERR; otherwise go to EXEC.
- EXEC: alu_en=1 for one cycle.
  - ALU and CALL go to WB.
  - LOAD and STORE go to MEM.
  - BRANCH: pc <= br_taken ? br_target : npc, retire, go to FETCH.
- MEM: dmem_req=1, dmem_we = (class==STORE). Hold until dmem_ready.
  - LOAD goes to WB.
  - STORE: pc <= npc, retire, go to FETCH.
- WB: rf_we=1 for one cycle. wb_sel = 0 for ALU, 1 for LOAD, 2 for CALL.
  - CALL: pc <= br_target. All others: pc <= npc.
  - Retire, go to FETCH.
- HALT and ERR: terminal, with all strobes 0. Only rst leaves them. halted=1 in HALT; bus_err=1 in ERR.
- Retire means instr_count+1, saturating at 0xFFFFFFFF.
- Wait timer:
  - Cleared on every entry to FETCH or MEM.
  - Increments each cycle that req=1 and ready=0.
  - When it reaches TIMEOUT with ready still 0, go to ERR and drop the request.
- A ready seen while the corresponding req=0 is ignored.
- pc arithmetic is modulo 2^IADDR_W: npc of all-ones is 0.

## Timing
- Zero-wait memories (ready in the first request cycle) give these latencies from FETCH entry to the next FETCH entry:
  - ALU and CALL: 4 cycles
  - LOAD: 5 cycles
  - STORE: 4 cycles
  - BRANCH: 3 cycles
- Each ready-low cycle adds one cycle.
- The new pc is visible the cycle after the retiring edge, together with imem_req=1.
- rst asserted mid-request drops the request on the next edge. The memory must tolerate an abandoned request.
- rst has priority over every transition, including the ERR timeout edge.
- Timeout: entering FETCH at cycle 0 with ready held low puts state=ERR at cycle TIMEOUT.

## Structure
- Package kgp_ctrl_pkg holds:
  - the state encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6
  - the op_class constants
  - the wb_sel constants
- Sub-module kgp_wait_timer: clear/enable/expire counter of width $clog2(TIMEOUT+1), shared by FETCH and MEM.
- pc, instr and instr_count live in the top module.

## Test plan
- Zero-wait ALU instruction, rst released at pc=0 → FETCH, DECODE, EXEC, WB. rf_we high for one cycle in WB with wb_sel=0. pc=1 and instr_count=1 at cycle 4.
- LOAD with dmem_ready delayed 3 cycles → dmem_req held 4 cycles, dmem_we=0, then WB with wb_sel=1. Total 8 cycles; pc=npc.
- BRANCH at pc=0x3FF with br_taken=0 → pc wraps to 0x000. With br_taken=1 and br_target=0x055 → pc=0x055. Both take 3 cycles and rf_we never asserts.
- CALL at pc=0x010, br_target=0x200 → wb_sel=2 in WB, npc=0x011 during WB, then pc=0x200.
- imem_ready held low, TIMEOUT=4 → state=ERR at cycle 4, bus_err=1, imem_req=0. rst clears everything and pc=RESET_PC.
- HALT class → halted=1 and no strobes for 20 cycles. An op_class of 7 → ERR. rst asserted during MEM wait → FETCH with all outputs at reset values.
